// File: rtl/conv_window_mac.sv
// 5x5 (or 3x3) windowed multiply-accumulate with bias, round-half-up,
// saturation and optional ReLU. One kernel row is accumulated per cycle.
module conv_window_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 11,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [25*DATA_W-1:0]     window,
    input  logic [25*DATA_W-1:0]     kernel,
    input  logic [DATA_W-1:0]        bias,
    input  logic                     relu_en,
    input  logic                     ksize_3,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        result,
    output logic                     overflow
);

    typedef enum logic [1:0] {IDLE, ACC, ROUND} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_W-1);

    state_t                    state;
    logic [25*DATA_W-1:0]      win_r, ker_r;
    logic signed [DATA_W-1:0]  bias_r;
    logic                      relu_r, k3_r;
    logic signed [ACC_W-1:0]   acc;
    logic [2:0]                row;

    logic signed [ACC_W-1:0]    row_sum;
    logic signed [DATA_W-1:0]   px, wt;
    logic signed [2*DATA_W-1:0] prod;

    // Dot product of the current row; columns 3..4 masked in 3x3 mode.
    always_comb begin
        row_sum = '0;
        px      = '0;
        wt      = '0;
        prod    = '0;
        for (int c = 0; c < 5; c++) begin
            px   = $signed(win_r[(int'(row)*5 + c)*DATA_W +: DATA_W]);
            wt   = $signed(ker_r[(int'(row)*5 + c)*DATA_W +: DATA_W]);
            prod = (2*DATA_W)'(px) * (2*DATA_W)'(wt);
            if (!(k3_r && c > 2))
                row_sum = row_sum + ACC_W'(prod);
        end
    end

    logic signed [ACC_W-1:0]  t, r;
    logic                     sat_hi, sat_lo;
    logic [DATA_W-1:0]        res_sat, res_final;

    always_comb begin
        t       = acc + (ACC_W'(bias_r) <<< FRAC_W) + RND;
        r       = t >>> FRAC_W;
        sat_hi  = r > SAT_MAX;
        sat_lo  = r < SAT_MIN;
        res_sat = sat_hi ? SAT_MAX[DATA_W-1:0] :
                  sat_lo ? SAT_MIN[DATA_W-1:0] : r[DATA_W-1:0];
        // Overflow reflects the clamp, even when ReLU later zeroes the value.
        res_final = (relu_r && res_sat[DATA_W-1]) ? '0 : res_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win_r    <= '0;
            ker_r    <= '0;
            bias_r   <= '0;
            relu_r   <= 1'b0;
            k3_r     <= 1'b0;
            acc      <= '0;
            row      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_r  <= window;
                        ker_r  <= kernel;
                        bias_r <= $signed(bias);
                        relu_r <= relu_en;
                        k3_r   <= ksize_3;
                        acc    <= '0;
                        row    <= '0;
                        busy   <= 1'b1;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + row_sum;
                    row <= row + 3'd1;
                    if (row == (k3_r ? 3'd2 : 3'd4))
                        state <= ROUND;
                end
                ROUND: begin
                    result   <= res_final;
                    overflow <= sat_hi | sat_lo;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed vector table plus handshake and reset sequences for conv_window_mac.
module tb_conv_window_mac;

    localparam int DW = 16;
    localparam int PW = 25*DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] window, kernel;
    logic [DW-1:0] bias;
    logic          relu_en, ksize_3;
    logic          busy, done, overflow;
    logic [DW-1:0] result;

    conv_window_mac dut (
        .clk(clk), .rst(rst), .start(start), .window(window), .kernel(kernel),
        .bias(bias), .relu_en(relu_en), .ksize_3(ksize_3), .busy(busy),
        .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [PW-1:0] win;
        logic [PW-1:0] ker;
        logic [DW-1:0] bias;
        logic          relu;
        logic          k3;
        int            exp_res;
        int            exp_ovf;
        int            exp_lat;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   ndone;

    function automatic logic [PW-1:0] fill(input logic [DW-1:0] v);
        logic [PW-1:0] p;
        for (int i = 0; i < 25; i++) p[i*DW +: DW] = v;
        return p;
    endfunction

    function automatic logic [PW-1:0] one_at(input int idx, input logic [DW-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        p[idx*DW +: DW] = v;
        return p;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        window  = v.win;
        kernel  = v.ker;
        bias    = v.bias;
        relu_en = v.relu;
        ksize_3 = v.k3;
    endtask

    // Returns cycles from the accepting edge to done (0 if none in budget).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin n = i; break; end
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, " busy"}, int'(busy), 1);
        wait_done(lat);
        chk({v.name, " latency"}, lat, v.exp_lat);
        chk({v.name, " result"}, int'($signed(result)), v.exp_res);
        chk({v.name, " overflow"}, int'(overflow), v.exp_ovf);
        chk({v.name, " busy_at_done"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{"s1_5x5",      fill(16'd2048), fill(16'd82),    16'd0,    1'b0, 1'b0, 2050,   0, 6};
        vecs[1] = '{"s2_3x3_bias", fill(16'd2048), fill(16'd82),    16'd2048, 1'b0, 1'b1, 2786,   0, 4};
        vecs[2] = '{"s3_sat_neg",  fill(16'd2048), fill(-16'sd2048), 16'd0,   1'b0, 1'b0, -32768, 1, 6};
        vecs[3] = '{"s3_relu",     fill(16'd2048), fill(-16'sd2048), 16'd0,   1'b1, 1'b0, 0,      1, 6};
        vecs[4] = '{"s3_sat_pos",  fill(16'd2048), fill(16'd2048),  16'd0,    1'b0, 1'b0, 32767,  1, 6};
        vecs[5] = '{"s4_half_up",  one_at(0, 16'd1), one_at(0, 16'd1024), 16'd0, 1'b0, 1'b0, 1, 0, 6};
        vecs[6] = '{"s4_below",    one_at(0, 16'd1), one_at(0, 16'd1023), 16'd0, 1'b0, 1'b0, 0, 0, 6};
        vecs[7] = '{"s4_neg_half", one_at(24, 16'hFFFF), one_at(24, 16'd1024), 16'd0, 1'b0, 1'b0, 0, 0, 6};

        rst = 1'b1; start = 1'b0; drive(vecs[0]);
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset overflow", int'(overflow), 0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Starts during busy with other data are ignored; inputs change after capture.
        @(negedge clk);
        drive(vecs[0]); start = 1'b1;
        @(posedge clk); #1;
        drive(vecs[4]);
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 1 || i == 3);
            @(posedge clk); #1;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("ignore_start done_count", ndone, 1);
        chk("ignore_start result", int'($signed(result)), 2050);
        chk("ignore_start overflow", int'(overflow), 0);

        // Start in the done cycle is accepted.
        run(vecs[1]);
        chk("b2b done_seen", int'(done), 1);
        drive(vecs[5]); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b latency", lat, 6);
        chk("b2b result", int'($signed(result)), 1);

        // Async reset during row 2 of ACC discards the computation.
        run(vecs[4]);
        @(negedge clk);
        drive(vecs[0]); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("mid_reset busy", int'(busy), 0);
        chk("mid_reset done", int'(done), 0);
        chk("mid_reset result", int'(result), 0);
        chk("mid_reset overflow", int'(overflow), 0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("post_reset idle", ndone, 0);
        run(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream consumer of the window RAM's 5x5 read port. Takes one 5x5 window of signed Q4.11 pixels (2048 = 1.0) and a 5x5 kernel of the same format.
- Computes the bias-added, rounded, saturated dot product, with optional ReLU, one kernel row per cycle.
- Feeds the feature-map write-back path and handshakes with the layer controller through start/busy/done.

Parameters:
- DATA_W, 16, width of pixel, weight, bias and result (signed).
- FRAC_W, 11, fractional bits of all fixed-point operands.
- ACC_W, 40, signed accumulator width; must be at least 2*DATA_W+5.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a computation; sampled only when busy=0.
- window  in  25*DATA_W  pixels; element [r][c] at bits [(r*5+c)*DATA_W +: DATA_W].
- kernel  in  25*DATA_W  weights; same packing as window.
- bias  in  DATA_W  signed Q4.11 bias.
- relu_en  in  1  clamp negative results to 0.
- ksize_3  in  1  use only rows/cols 0..2 (3x3 kernel); otherwise 5x5.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  DATA_W  signed Q4.11 output, held until the next done.
- overflow  out  1  saturation occurred in the last result, held with result.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, overflow=0, accumulator and row counter cleared.
- FSM states: IDLE, ACC, ROUND.
- IDLE: on a clk edge with start=1, capture window, kernel, bias, relu_en and ksize_3 into internal registers. Then clear acc, set row=0, busy=1, go to ACC. Inputs may change freely after capture.
- ACC: each cycle, compute acc += sum over c of (w[row][c]*k[row][c]).
  - Products are full 2*DATA_W signed.
  - For ksize_3, columns 3..4 contribute 0.
  - row increments; last row is 4 (5x5) or 2 (3x3); after the last row go to ROUND.
- ROUND, single cycle:
  - t = acc + (sign-extended bias << FRAC_W) + (1 << (FRAC_W-1)).
  - r = t >>> FRAC_W (arithmetic shift; round half up toward +inf).
  - Saturate r to [-32768, 32767]; overflow = 1 iff clamping applied.
  - If relu_en and the saturated r < 0, then result = 0. overflow is still reported from the pre-ReLU saturation.
  - Register result and overflow, pulse done=1, set busy=0, return to IDLE.
- Latency: start sampled at edge T0; done high in the cycle after edge T6 (5x5) or T4 (3x3). That is 6 or 4 cycles from start to done.
- done and busy are never high together. start in the cycle where done=1 is accepted, giving back-to-back throughput of 6 or 4 cycles.
- start while busy=1 is ignored entirely: no capture, no restart, no error.
- result and overflow change only in ROUND or on reset.
- Reset mid-operation: the computation is discarded with no done pulse. The next start behaves as from power-up.
- Accumulator cannot overflow at ACC_W=40 (25 products of at most 2^30 each).

Test Plan:
1. Scale and sum:
   - Stimulus: all pixels 2048, all weights 82, bias 0, 5x5, relu off.
   - Response: done exactly 6 cycles after start, result=2050, overflow=0.
2. 3x3 mode and bias:
   - Stimulus: same inputs as scenario 1 with ksize_3=1 and bias 2048.
   - Response: done after 4 cycles, result=738+2048=2786, overflow=0.
3. Saturation and ReLU:
   - Stimulus: pixels 2048, weights -2048, 5x5, relu off; then repeat with relu on.
   - Response: relu off gives result=-32768, overflow=1; relu on gives result=0, overflow=1.
   - Stimulus: pixels 2048, weights 2048.
   - Response: result=32767, overflow=1.
4. Rounding:
   - Stimulus: only w[0][0]=1 and k[0][0]=1024, all else 0, bias 0.
   - Response: result=1.
   - Stimulus: same with k[0][0]=1023.
   - Response: result=0.
   - Stimulus: w[4][4]=-1, k[4][4]=1024.
   - Response: result=0 (half rounds up).
5. Handshake:
   - Stimulus: pulse start twice during busy with different data.
   - Response: only the first capture is used and a single done occurs.
   - Stimulus: start asserted in the done cycle.
   - Response: accepted; the second done follows 6 cycles later.
   - Stimulus: change inputs one cycle after start.
   - Response: result unaffected.
6. Reset:
   - Stimulus: assert rst asynchronously (between edges) during ACC row 2.
   - Response: busy, done, result and overflow go to 0 immediately, with no done pulse.
   - Stimulus: scenario 1 after release.
   - Response: result=2050.
